// File: rtl/ai_i2s_frame_fifo.sv
// Frame-in / word-out sample FIFO: whole NUM_CH frames are pushed, and words pop show-ahead in channel order.
// Zero-latency read of the head word; writes while full and reads while empty are dropped and flagged sticky.
module ai_i2s_frame_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 16,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [CW-1:0]                rd_ch,
  output logic                         rd_last,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [LW-1:0]                level,
  input  logic [LW-1:0]                af_thresh,
  input  logic [LW-1:0]                ae_thresh,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = NUM_CH * DATA_WIDTH;

  logic [FW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [CW-1:0]         rd_ch_q, rd_ch_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  pop;
  logic                  last_ch;
  logic [FW-1:0]         head_frame;
  logic [DATA_WIDTH-1:0] head_word;

  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);
  assign level        = level_q;
  assign rd_ch        = rd_ch_q;
  assign last_ch      = (rd_ch_q == CW'(NUM_CH - 1));
  assign rd_last      = last_ch;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Flush swallows both ports for the cycle, so nothing is stored or consumed.
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;
  assign pop    = rd_acc & last_ch;

  always_comb begin
    head_frame = mem_q[rd_ptr_q];
    head_word  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch_q == CW'(k)) begin
        head_word = head_frame[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rd_data = empty ? '0 : head_word;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_ch_d     = rd_ch_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      rd_ch_d  = '0;
    end else begin
      // Set wins over a simultaneous clear.
      if (wr_en & full) begin
        overflow_d = 1'b1;
      end
      if (rd_en & empty) begin
        underflow_d = 1'b1;
      end

      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end

      if (rd_acc) begin
        if (last_ch) begin
          rd_ch_d  = '0;
          rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end else begin
          rd_ch_d = rd_ch_q + CW'(1);
        end
      end

      case ({wr_acc, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_ch_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_ch_q     <= rd_ch_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ai_i2s_frame_fifo.sv
// Randomised and directed bench for ai_i2s_frame_fifo against a queue-of-frames reference model.
module tb_ai_i2s_frame_fifo;

  localparam int DW = 32;
  localparam int NC = 2;
  localparam int DP = 5;
  localparam int LW = $clog2(DP + 1);
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int FW = NC * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [FW-1:0] wr_data = '0;
  logic          full, almost_full;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] rd_ch;
  logic          rd_last, empty, almost_empty;
  logic [LW-1:0] level;
  logic [LW-1:0] af_thresh = LW'(4);
  logic [LW-1:0] ae_thresh = LW'(1);
  logic          err_clr = 1'b0;
  logic          overflow, underflow;

  ai_i2s_frame_fifo #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_ch(rd_ch), .rd_last(rd_last),
    .empty(empty), .almost_empty(almost_empty), .level(level),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: frames in arrival order, index of next channel in the head frame.
  logic [FW-1:0] mq[$];
  int            hc = 0;
  bit            m_of = 1'b0;
  bit            m_uf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hc   = 0;
    m_of = 1'b0;
    m_uf = 1'b0;
  endtask

  task automatic check_all();
    int            lvl;
    logic [FW-1:0] f;
    logic [DW-1:0] exp_d;
    lvl   = mq.size();
    exp_d = '0;
    if (lvl != 0) begin
      f     = mq[0];
      exp_d = f[hc*DW +: DW];
    end
    chk("level", 64'(level), 64'(lvl));
    chk("empty", 64'(empty), 64'(lvl == 0));
    chk("full", 64'(full), 64'(lvl == DP));
    chk("almost_full", 64'(almost_full), 64'(lvl >= int'(af_thresh)));
    chk("almost_empty", 64'(almost_empty), 64'(lvl <= int'(ae_thresh)));
    chk("rd_data", 64'(rd_data), 64'(exp_d));
    chk("rd_ch", 64'(rd_ch), 64'(hc));
    chk("rd_last", 64'(rd_last), 64'(hc == NC - 1));
    chk("overflow", 64'(overflow), 64'(m_of));
    chk("underflow", 64'(underflow), 64'(m_uf));
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, check at the next fall.
  task automatic cyc(input bit w, input logic [FW-1:0] d, input bit r,
                     input bit f = 1'b0, input bit c = 1'b0);
    int lvl;
    bit was_full, was_empty;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    err_clr = c;
    @(posedge clk);
    lvl       = mq.size();
    was_full  = (lvl == DP);
    was_empty = (lvl == 0);
    if (f) begin
      mq.delete();
      hc = 0;
      if (c) begin
        m_of = 1'b0;
        m_uf = 1'b0;
      end
    end else begin
      if (w && was_full) m_of = 1'b1;
      else if (c)        m_of = 1'b0;
      if (r && was_empty) m_uf = 1'b1;
      else if (c)         m_uf = 1'b0;
      if (r && !was_empty) begin
        hc++;
        if (hc == NC) begin
          mq.delete(0);
          hc = 0;
        end
      end
      if (w && !was_full) mq.push_back(d);
    end
    @(negedge clk);
    check_all();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
  endtask

  function automatic logic [FW-1:0] frm(input logic [DW-1:0] l, input logic [DW-1:0] r);
    return {r, l};
  endfunction

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // Basic stereo ordering
    cyc(1, frm(32'h11, 32'h12), 0);
    cyc(1, frm(32'h21, 32'h22), 0);
    chk("basic_level", 64'(level), 64'd2);
    chk("basic_w0", 64'(rd_data), 64'h11);
    cyc(0, '0, 1);
    chk("basic_w1", 64'(rd_data), 64'h12);
    chk("basic_w1_last", 64'(rd_last), 64'd1);
    cyc(0, '0, 1);
    chk("basic_w2", 64'(rd_data), 64'h21);
    cyc(0, '0, 1);
    chk("basic_w3", 64'(rd_data), 64'h22);
    cyc(0, '0, 1);
    chk("basic_empty", 64'(empty), 64'd1);
    chk("basic_zero", 64'(rd_data), 64'd0);

    // Fill, overflow, wrap
    for (int i = 0; i < DP; i++) cyc(1, frm(32'h100 + i, 32'h200 + i), 0);
    chk("wrap_full", 64'(full), 64'd1);
    cyc(1, frm(32'hDEAD, 32'hBEEF), 0);
    chk("wrap_ovf", 64'(overflow), 64'd1);
    chk("wrap_lvl", 64'(level), 64'd5);
    for (int i = 0; i < 2 * NC; i++) cyc(0, '0, 1);
    cyc(1, frm(32'h300, 32'h400), 0);
    cyc(1, frm(32'h301, 32'h401), 0);
    for (int i = 0; i < DP * NC; i++) cyc(0, '0, 1);
    chk("wrap_drained", 64'(empty), 64'd1);
    cyc(0, '0, 0, 0, 1);
    chk("wrap_clr", 64'(overflow), 64'd0);

    // Simultaneous push and pop
    for (int i = 0; i < 3; i++) cyc(1, frm($urandom, $urandom), 0);
    cyc(0, '0, 1);
    cyc(1, frm(32'h55, 32'h66), 1);
    chk("sim_lvl3", 64'(level), 64'd3);
    cyc(1, frm($urandom, $urandom), 0);
    cyc(1, frm($urandom, $urandom), 0);
    chk("sim_full", 64'(full), 64'd1);
    cyc(0, '0, 1);
    cyc(1, frm(32'h77, 32'h88), 1);
    chk("sim_drop_lvl", 64'(level), 64'd4);
    chk("sim_drop_ovf", 64'(overflow), 64'd1);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 0, 1);

    // Partial head frame then flush
    cyc(1, frm(32'hA0, 32'hA1), 0);
    cyc(0, '0, 1);
    chk("part_lvl", 64'(level), 64'd1);
    chk("part_ch", 64'(rd_ch), 64'd1);
    cyc(1, frm(32'hEE, 32'hEE), 1, 1, 0);
    chk("flush_lvl", 64'(level), 64'd0);
    chk("flush_ch", 64'(rd_ch), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_noerr", 64'(overflow | underflow), 64'd0);
    cyc(1, frm(32'hB0, 32'hB1), 0);
    chk("flush_next", 64'(rd_data), 64'hB0);
    cyc(0, '0, 0, 1, 0);

    // Thresholds while filling
    af_thresh = LW'(4);
    ae_thresh = LW'(1);
    @(negedge clk);
    chk("thr_ae0", 64'(almost_empty), 64'd1);
    for (int i = 1; i <= DP; i++) begin
      cyc(1, frm($urandom, $urandom), 0);
      chk("thr_af", 64'(almost_full), 64'(i >= 4));
      chk("thr_ae", 64'(almost_empty), 64'(i <= 1));
    end
    cyc(0, '0, 0, 1, 0);

    // Sticky underflow and set-beats-clear
    cyc(0, '0, 1);
    chk("uf_set", 64'(underflow), 64'd1);
    cyc(0, '0, 1, 0, 1);
    chk("uf_keep", 64'(underflow), 64'd1);
    cyc(0, '0, 0, 0, 1);
    chk("uf_clr", 64'(underflow), 64'd0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) cyc(1, frm($urandom, $urandom), 0);
    chk("arst_pre", 64'(level), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_lvl", 64'(level), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // Random traffic with alternating producer/consumer bias
    for (int i = 0; i < 3000; i++) begin
      int  wp, rp;
      bit  f, c;
      wp = ((i / 150) % 2 == 0) ? 70 : 30;
      rp = 100 - wp + 20;
      if (i % 97 == 0) begin
        af_thresh = LW'($urandom_range(0, DP + 1));
        ae_thresh = LW'($urandom_range(0, DP + 1));
      end
      f = ($urandom_range(0, 59) == 0);
      c = !f && ($urandom_range(0, 19) == 0);
      cyc($urandom_range(0, 99) < wp, {$urandom, $urandom},
          $urandom_range(0, 99) < rp, f, c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ai_i2s_frame_fifo.md
Name: ai_i2s_frame_fifo

Overview:
Parametrised synchronous sample FIFO for the I2S datapath. It stores whole audio frames (NUM_CH channel words written in one push) and returns them one channel word per pop, in channel order. It adds a non-power-of-2 depth, level and programmable almost-full/almost-empty outputs, flush, and sticky overflow/underflow flags. It sits between the frame assembler and the serialiser, in both the TX and RX paths.

Parameters:
DATA_WIDTH, 32, bits per channel sample word
NUM_CH, 2, channels per frame (>=1; 2 = stereo L/R, up to 8 for TDM)
DEPTH, 16, capacity in frames (>=2; any integer, not restricted to a power of 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of contents
wr_en  in  1  push one frame
wr_data  in  NUM_CH*DATA_WIDTH  frame; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
full  out  1  level == DEPTH
almost_full  out  1  level >= af_thresh
rd_en  in  1  pop one channel word
rd_data  out  DATA_WIDTH  head word (show-ahead)
rd_ch  out  max(1,$clog2(NUM_CH))  channel index of rd_data
rd_last  out  1  rd_ch == NUM_CH-1
empty  out  1  level == 0
almost_empty  out  1  level <= ae_thresh
level  out  $clog2(DEPTH+1)  stored frames, including a partially read head frame
af_thresh  in  $clog2(DEPTH+1)  almost-full threshold
ae_thresh  in  $clog2(DEPTH+1)  almost-empty threshold
err_clr  in  1  clear sticky error flags
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr, level, rd_ch and the error flags go to 0.
  - Outputs during and after reset: empty=1, full=0, rd_data=0, rd_last=(NUM_CH==1).
  - almost_full and almost_empty follow their comparisons combinationally.
  - Memory contents are not reset.
- Write:
  - Accepted when wr_en & ~full. Stores the frame at wr_ptr.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
  - A write while full is dropped, even if a frame pops in the same cycle.
- Read (show-ahead, zero latency):
  - When ~empty, rd_data = channel rd_ch of the frame at rd_ptr, combinationally. When empty, rd_data = 0.
  - rd_en & ~empty consumes one word.
  - If rd_ch < NUM_CH-1: rd_ch increments.
  - If rd_ch == NUM_CH-1: rd_ch goes to 0, rd_ptr increments (wraps DEPTH-1 to 0) and the frame pops.
  - A read while empty is ignored.
- Level:
  - Push only: +1. Pop only: -1.
  - Push and pop in the same cycle: unchanged.
  - level never exceeds DEPTH and never goes below 0.
- Flags:
  - full, empty, almost_full and almost_empty are combinational from the level register.
  - af_thresh=0 gives almost_full=1 always. ae_thresh>=DEPTH gives almost_empty=1 always.
- Errors:
  - overflow sets on wr_en & full. underflow sets on rd_en & empty.
  - err_clr clears both next cycle.
  - If a set and a clear happen in the same cycle, set wins.
- Flush:
  - On the next edge, wr_ptr, rd_ptr, level and rd_ch go to 0.
  - wr_en and rd_en in the flush cycle are ignored, and no error flags are set.
  - Existing error flags are kept.
  - A partially read head frame is discarded.
- Reset mid-operation: asserting rst immediately returns the block to the reset state. Contents are lost.

Test Plan:
- NUM_CH=2, DEPTH=5: reset, push frames {L=0x11,R=0x12}, {L=0x21,R=0x22} -> level=2. Four pops give 0x11(ch0), 0x12(ch1, rd_last=1), 0x21, 0x22. Then empty=1, rd_data=0.
- DEPTH=5 wrap: push 5 frames -> full=1. A 6th push sets overflow=1, level stays 5. Pop 2 frames, push 2 more -> pointers wrap 4->0, data is returned in exact FIFO order.
- Simultaneous ops: level=3, push plus a final-channel pop in the same cycle -> level stays 3. With full=1, push plus a last-channel pop -> write dropped, overflow=1, level=4.
- Partial frame: push 1 frame, pop ch0 only -> level=1, rd_ch=1. Assert flush -> level=0, rd_ch=0, empty=1. The next push reads back from ch0.
- Thresholds: af_thresh=4, ae_thresh=1. Fill 0->5 -> almost_full rises at level 4, almost_empty falls at level 2.
- Errors and reset: rd_en while empty -> underflow=1. err_clr and rd_en both high in the same cycle -> underflow stays 1; err_clr alone -> 0. With level=3, assert rst asynchronously mid-cycle -> level=0, empty=1 immediately.
